// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter_pkg
// Description : Shared opcodes, cache enable level and FSM state encoding
//               for the dual-core cache arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_arbiter_pkg;

    // Cache opcodes as carried in the top field of the cache vector
    localparam logic [1:0] OP_FLASH   = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_INVALID = 2'b11;

    // Active level of the cache enable input
    localparam logic CACHE_ENABLE = 1'b0;

    // Arbiter FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin pick. With both requesters active the
//               one that was not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    // Pick the sole requester, or alternate away from the last winner
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = 1'b0;
        case (req_i)
            2'b01:   gnt_id_o = 1'b0;
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ~last_grant_i;
            default: gnt_id_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Shares one single-ported cache between two cores. Grants
//               round-robin, issues one cache access per transaction and
//               returns the captured result with a one-cycle ack pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int TAG_WIDTH    = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 2,
    parameter int LINE_WIDTH   = OPCODE_WIDTH + TAG_WIDTH + DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    c0_req,
    input  logic [OPCODE_WIDTH-1:0] c0_op,
    input  logic [TAG_WIDTH-1:0]    c0_tag,
    input  logic [DATA_WIDTH-1:0]   c0_wdata,
    output logic                    c0_ack,
    output logic [DATA_WIDTH-1:0]   c0_rdata,
    output logic                    c0_hit,
    input  logic                    c1_req,
    input  logic [OPCODE_WIDTH-1:0] c1_op,
    input  logic [TAG_WIDTH-1:0]    c1_tag,
    input  logic [DATA_WIDTH-1:0]   c1_wdata,
    output logic                    c1_ack,
    output logic [DATA_WIDTH-1:0]   c1_rdata,
    output logic                    c1_hit,
    output logic [LINE_WIDTH-1:0]   cache_vector,
    output logic                    cache_enable_n,
    input  logic [DATA_WIDTH-1:0]   cache_data,
    input  logic                    cache_hit,
    output logic                    busy
);

    state_t                  state_q;
    logic                    last_grant_q;
    logic                    gnt_id_q;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic                    c0_ack_q,   c1_ack_q;
    logic [DATA_WIDTH-1:0]   c0_rdata_q, c1_rdata_q;
    logic                    c0_hit_q,   c1_hit_q;
    logic [LINE_WIDTH-1:0]   vector_q;
    logic                    enable_n_q;
    logic                    busy_q;

    logic                    gnt_valid;
    logic                    gnt_id;
    logic [OPCODE_WIDTH-1:0] sel_op;
    logic [TAG_WIDTH-1:0]    sel_tag;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_hit;

    rr_arb2 u_rr_arb2 (
        .req_i        ({c1_req, c0_req}),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    assign sel_op    = gnt_id ? c1_op    : c0_op;
    assign sel_tag   = gnt_id ? c1_tag   : c0_tag;
    assign sel_wdata = gnt_id ? c1_wdata : c0_wdata;

    // Shape the cache result by opcode; flash never refreshes the cache hit flag
    always_comb begin
        resp_rdata = '0;
        resp_hit   = 1'b0;
        case (op_q)
            OPCODE_WIDTH'(OP_READ): begin
                resp_rdata = cache_data;
                resp_hit   = cache_hit;
            end
            OPCODE_WIDTH'(OP_WRITE): resp_hit = cache_hit;
            OPCODE_WIDTH'(OP_FLASH): resp_hit = 1'b0;
            default:                 resp_hit = 1'b0;
        endcase
    end

    // Arbiter FSM with all outputs registered on the state transitions
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_id_q     <= 1'b0;
            op_q         <= '0;
            c0_ack_q     <= 1'b0;
            c1_ack_q     <= 1'b0;
            c0_rdata_q   <= '0;
            c1_rdata_q   <= '0;
            c0_hit_q     <= 1'b0;
            c1_hit_q     <= 1'b0;
            vector_q     <= '0;
            enable_n_q   <= ~CACHE_ENABLE;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        gnt_id_q <= gnt_id;
                        op_q     <= sel_op;
                        busy_q   <= 1'b1;
                        if (sel_op == OPCODE_WIDTH'(OP_INVALID)) begin
                            // Invalid opcode bypasses the cache entirely
                            state_q <= RESP;
                            if (gnt_id) begin
                                c1_ack_q   <= 1'b1;
                                c1_rdata_q <= '0;
                                c1_hit_q   <= 1'b0;
                            end else begin
                                c0_ack_q   <= 1'b1;
                                c0_rdata_q <= '0;
                                c0_hit_q   <= 1'b0;
                            end
                        end else begin
                            state_q    <= ISSUE;
                            enable_n_q <= CACHE_ENABLE;
                            vector_q   <= {sel_op, sel_tag, sel_wdata};
                        end
                    end
                end
                ISSUE: begin
                    enable_n_q <= ~CACHE_ENABLE;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    state_q <= RESP;
                    if (gnt_id_q) begin
                        c1_ack_q   <= 1'b1;
                        c1_rdata_q <= resp_rdata;
                        c1_hit_q   <= resp_hit;
                    end else begin
                        c0_ack_q   <= 1'b1;
                        c0_rdata_q <= resp_rdata;
                        c0_hit_q   <= resp_hit;
                    end
                end
                RESP: begin
                    c0_ack_q     <= 1'b0;
                    c1_ack_q     <= 1'b0;
                    last_grant_q <= gnt_id_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c0_ack         = c0_ack_q;
    assign c0_rdata       = c0_rdata_q;
    assign c0_hit         = c0_hit_q;
    assign c1_ack         = c1_ack_q;
    assign c1_rdata       = c1_rdata_q;
    assign c1_hit         = c1_hit_q;
    assign cache_vector   = vector_q;
    assign cache_enable_n = enable_n_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Directed scoreboard bench for cache_arbiter with a small
//               behavioural cache attached to the cache port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c0_req = 1'b0, c1_req = 1'b0;
    logic [1:0]  c0_op = '0, c1_op = '0;
    logic [3:0]  c0_tag = '0, c1_tag = '0;
    logic [7:0]  c0_wdata = '0, c1_wdata = '0;
    logic        c0_ack, c1_ack, c0_hit, c1_hit;
    logic [7:0]  c0_rdata, c1_rdata;
    logic [13:0] cache_vector;
    logic        cache_enable_n;
    logic [7:0]  cache_data = '0;
    logic        cache_hit = 1'b0;
    logic        busy;

    cache_arbiter #(
        .TAG_WIDTH    (4),
        .DATA_WIDTH   (8),
        .OPCODE_WIDTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .c0_req         (c0_req),
        .c0_op          (c0_op),
        .c0_tag         (c0_tag),
        .c0_wdata       (c0_wdata),
        .c0_ack         (c0_ack),
        .c0_rdata       (c0_rdata),
        .c0_hit         (c0_hit),
        .c1_req         (c1_req),
        .c1_op          (c1_op),
        .c1_tag         (c1_tag),
        .c1_wdata       (c1_wdata),
        .c1_ack         (c1_ack),
        .c1_rdata       (c1_rdata),
        .c1_hit         (c1_hit),
        .cache_vector   (cache_vector),
        .cache_enable_n (cache_enable_n),
        .cache_data     (cache_data),
        .cache_hit      (cache_hit),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Behavioural cache: samples on enable, registered outputs next cycle.
    // Write reports whether the tag was already valid and echoes wdata on
    // data_out; flash invalidates everything and leaves the hit flag alone.
    logic [7:0]  mem [16];
    logic [15:0] vld = '0;
    always @(posedge clk) begin
        if (cache_enable_n == 1'b0) begin
            case (cache_vector[13:12])
                2'b10: begin
                    cache_hit              <= vld[cache_vector[11:8]];
                    cache_data             <= cache_vector[7:0];
                    mem[cache_vector[11:8]] <= cache_vector[7:0];
                    vld[cache_vector[11:8]] <= 1'b1;
                end
                2'b01: begin
                    cache_hit  <= vld[cache_vector[11:8]];
                    cache_data <= vld[cache_vector[11:8]] ? mem[cache_vector[11:8]] : 8'h00;
                end
                2'b00: begin
                    vld        <= '0;
                    cache_data <= 8'hEE;
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        logic       hit;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [13:0] vq[$];
    int compared   = 0;
    int mismatched = 0;
    int en_lows    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        compared   = compared + 1;
        mismatched = mismatched + 1;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares cache accesses and acks against the queued expectations
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (cache_enable_n === 1'b0) begin
            en_lows = en_lows + 1;
            if (vq.size() == 0) fail_now("unexpected cache_enable_n low");
            else check("cache_vector", 32'(cache_vector), 32'(vq.pop_front()));
        end
        if (c0_ack === 1'b1) begin
            if (q0.size() == 0) fail_now("unexpected c0_ack");
            else begin
                e = q0.pop_front();
                check("c0_ack cycle", cyc, e.cyc);
                check("c0_rdata", 32'(c0_rdata), 32'(e.rdata));
                check("c0_hit", 32'(c0_hit), 32'(e.hit));
            end
        end
        if (c1_ack === 1'b1) begin
            if (q1.size() == 0) fail_now("unexpected c1_ack");
            else begin
                e = q1.pop_front();
                check("c1_ack cycle", cyc, e.cyc);
                check("c1_rdata", 32'(c1_rdata), 32'(e.rdata));
                check("c1_hit", 32'(c1_hit), 32'(e.hit));
            end
        end
    end

    // Issue one request from a negedge in IDLE; returns at the next IDLE negedge
    task automatic do_req(input int core, input logic [1:0] op, input logic [3:0] tag,
                          input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_hit,
                          input int lat, input bit push_vec);
        exp_t e;
        int   n;
        logic a;
        e.cyc   = cyc + lat;
        e.rdata = exp_rd;
        e.hit   = exp_hit;
        if (push_vec) vq.push_back({op, tag, wd});
        if (core == 0) begin
            c0_op = op; c0_tag = tag; c0_wdata = wd; c0_req = 1'b1;
            q0.push_back(e);
        end else begin
            c1_op = op; c1_tag = tag; c1_wdata = wd; c1_req = 1'b1;
            q1.push_back(e);
        end
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
            a = (core == 0) ? c0_ack : c1_ack;
        end while (a !== 1'b1 && n < 20);
        if (a !== 1'b1) fail_now($sformatf("core %0d ack timeout", core));
        if (core == 0) c0_req = 1'b0;
        else           c1_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1);
    end

    initial begin
        int n0;
        // Reset state
        repeat (3) @(negedge clk);
        check("reset c0_ack", 32'(c0_ack), 0);
        check("reset c1_ack", 32'(c1_ack), 0);
        check("reset c0_rdata", 32'(c0_rdata), 0);
        check("reset c1_hit", 32'(c1_hit), 0);
        check("reset cache_vector", 32'(cache_vector), 0);
        check("reset cache_enable_n", 32'(cache_enable_n), 1);
        check("reset busy", 32'(busy), 0);
        reset = 1'b0;

        // Contention after reset: core 0 first, core 1 four cycles later
        vq.push_back({2'b01, 4'd3, 8'h00});
        vq.push_back({2'b01, 4'd5, 8'h00});
        fork
            do_req(0, 2'b01, 4'd3, 8'h00, 8'h00, 1'b0, 3, 1'b0);
            do_req(1, 2'b01, 4'd5, 8'h00, 8'h00, 1'b0, 7, 1'b0);
        join

        // Write then read back
        do_req(0, 2'b10, 4'd3, 8'h5A, 8'h00, 1'b0, 3, 1'b1);
        do_req(0, 2'b01, 4'd3, 8'h00, 8'h5A, 1'b1, 3, 1'b1);

        // Repeat contention after core 0 was served: core 1 first
        vq.push_back({2'b10, 4'd3, 8'hC3});
        vq.push_back({2'b10, 4'd5, 8'h33});
        fork
            do_req(0, 2'b10, 4'd5, 8'h33, 8'h00, 1'b0, 7, 1'b0);
            do_req(1, 2'b10, 4'd3, 8'hC3, 8'h00, 1'b1, 3, 1'b0);
        join

        // Read miss on a never-written tag
        do_req(1, 2'b01, 4'd9, 8'h00, 8'h00, 1'b0, 3, 1'b1);

        // Invalid opcode: one-cycle turnaround, cache untouched
        n0 = en_lows;
        do_req(0, 2'b11, 4'd1, 8'hFF, 8'h00, 1'b0, 1, 1'b0);
        check("invalid op enable untouched", en_lows, n0);

        // Hit read, flash (cache hit flag still high), then miss on flashed tag
        do_req(1, 2'b01, 4'd3, 8'h00, 8'hC3, 1'b1, 3, 1'b1);
        do_req(1, 2'b00, 4'd0, 8'h77, 8'h00, 1'b0, 3, 1'b1);
        do_req(0, 2'b01, 4'd5, 8'h00, 8'h00, 1'b0, 3, 1'b1);

        // Reset during WAIT aborts the write without an ack
        vq.push_back({2'b10, 4'd7, 8'h11});
        c0_op = 2'b10; c0_tag = 4'd7; c0_wdata = 8'h11; c0_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b1;
        c0_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort c0_ack", 32'(c0_ack), 0);
        check("abort c1_ack", 32'(c1_ack), 0);
        check("abort cache_enable_n", 32'(cache_enable_n), 1);
        check("abort busy", 32'(busy), 0);
        check("abort cache_vector", 32'(cache_vector), 0);

        // After reset core 0 wins contention again
        vq.push_back({2'b01, 4'd7, 8'h00});
        vq.push_back({2'b01, 4'd5, 8'h00});
        fork
            do_req(0, 2'b01, 4'd7, 8'h00, 8'h11, 1'b1, 3, 1'b0);
            do_req(1, 2'b01, 4'd5, 8'h00, 8'h00, 1'b0, 7, 1'b0);
        join
        do_req(1, 2'b01, 4'd7, 8'h00, 8'h11, 1'b1, 3, 1'b1);

        repeat (4) @(negedge clk);
        check("c0 expectations drained", q0.size(), 0);
        check("c1 expectations drained", q1.size(), 0);
        check("vector expectations drained", vq.size(), 0);
        check("cache enable low cycles", en_lows, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares one `cache` instance between the two cores of the dual-core processor.
- Arbitrates between the core request ports using round-robin.
- Packs the granted request into the cache's {opcode, tag, data} vector and drives the active-low cache enable for exactly one cycle.
- Captures the registered cache result and returns it to the granted core with a one-cycle ack pulse.

Parameters:
- TAG_WIDTH, 4, tag field width; must match the cache.
- DATA_WIDTH, 8, data field width; must match the cache.
- OPCODE_WIDTH, 2, opcode field width; must match the cache.
- LINE_WIDTH, OPCODE_WIDTH+TAG_WIDTH+DATA_WIDTH, width of the packed cache vector.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- c0_req  in  1  core 0 request; held high with fields stable until c0_ack.
- c0_op  in  OPCODE_WIDTH  core 0 opcode: 00 flash, 01 read, 10 write, 11 invalid.
- c0_tag  in  TAG_WIDTH  core 0 tag.
- c0_wdata  in  DATA_WIDTH  core 0 write data.
- c0_ack  out  1  one-cycle completion pulse to core 0.
- c0_rdata  out  DATA_WIDTH  core 0 result data; valid while c0_ack=1.
- c0_hit  out  1  core 0 hit flag; valid while c0_ack=1.
- c1_req, c1_op, c1_tag, c1_wdata, c1_ack, c1_rdata, c1_hit: same as core 0, for core 1.
- cache_vector  out  LINE_WIDTH  {op, tag, data} to cache vector_in.
- cache_enable_n  out  1  to cache enable; 0 = enabled.
- cache_data  in  DATA_WIDTH  from cache data_out.
- cache_hit  in  1  from cache hit_miss_out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (sync): state=IDLE; all acks 0; all rdata 0; all hit 0; cache_vector 0; cache_enable_n 1; busy 0; last_grant=1, so core 0 wins the first contention. Reset in any state aborts the transaction immediately; no ack is issued for the aborted request.
- FSM states are IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that core.
  - Both req: grant !last_grant.
  - On grant, latch gnt_id and the core's op/tag/wdata.
  - If op=11: skip the cache and go to RESP with rdata=0, hit=0.
  - Otherwise go to ISSUE.
- ISSUE (one cycle): cache_enable_n=0; cache_vector={op,tag,wdata}. The cache samples at the end of this cycle. Next state: WAIT.
- WAIT (one cycle): cache_enable_n=1. Cache outputs are valid in this cycle. The arbiter captures them at the end of the cycle:
  - read: rdata=cache_data, hit=cache_hit.
  - write: rdata=0, hit=cache_hit.
  - flash: rdata=0, hit=0, because the cache does not update hit on flash.
  - Next state: RESP.
- RESP (one cycle): ack of gnt_id=1 with rdata/hit; last_grant=gnt_id; next state IDLE. The non-granted core's ack stays 0.
- Latency: req seen in IDLE at cycle T gives ISSUE at T+1, WAIT at T+2, ack at T+3. Invalid op gives ack at T+1.
- Requester rule: a core drops req in the cycle after it sees ack. IDLE re-samples in that cycle, so a held req is a new request. A losing requester keeps req high and is served next, i.e. worst-case wait is one transaction.
- cache_enable_n is never 0 outside ISSUE. cache_vector holds its last value outside ISSUE.
- rdata/hit hold their values after ack; they are only meaningful while ack=1.
- Back-to-back: the minimum issue-to-issue spacing is 4 cycles. There is no pipelining, because the cache is single-ported.

Decomposition:
- Shared package holds:
  - OP_FLASH/OP_READ/OP_WRITE/OP_INVALID;
  - CACHE_ENABLE=0;
  - FSM state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
- One sub-module: rr_arb2. Inputs req[1:0] and last_grant; outputs gnt_valid and gnt_id. Purely combinational pick logic.

Test Plan:
- Reset, then c0 writes tag 3, data 0x5A; later c0 reads tag 3 -> c0_ack at T+3, c0_rdata=0x5A, c0_hit=1; cache_enable_n low exactly one cycle per transaction.
- c0 and c1 both request read in the same IDLE cycle after reset -> c0 acked first, c1 acked 4 cycles later. Repeat contention -> c1 first (alternation).
- c1 reads tag 9 never written -> c1_hit=0, c1_rdata=0.
- c0 op=11 -> c0_ack at T+1, rdata=0, hit=0; cache_enable_n stays 1 throughout.
- c1 flash after writes -> ack with hit=0; then a read of a previously written tag -> hit=0.
- Assert reset during WAIT -> no ack, cache_enable_n=1, state IDLE. Next c1 req is granted normally, with core 0 winning any contention.
